// File: rtl/rf_writeback_file.sv
// Writeback queue in front of an 8 x 16-bit register file, with two forwarding operand read ports.
// Optional build macro RF_ZERO_REG_EN: register 0 reads as zero and writes to it are dropped.
module rf_writeback_file #(
   parameter int          WB_DEPTH = 2,
   parameter logic [15:0] RST_VAL  = 16'h0000
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_wbValid,
   input  logic [2:0]  i_wbAddr,
   input  logic [15:0] i_wbData,
   output logic        o_wbReady,
   input  logic        i_wrHold,
   input  logic [2:0]  i_rdAddr1,
   input  logic [2:0]  i_rdAddr2,
   output logic [15:0] o_rdData1,
   output logic [15:0] o_rdData2,
   output logic [7:0]  o_pending,
   output logic        o_empty
);

   // Queue storage is sized for the largest legal depth; only WB_DEPTH slots are ever used.
   logic [2:0]  qAddr_r [0:3];
   logic [15:0] qData_r [0:3];
   logic [15:0] regs_r  [0:7];
   logic [2:0]  count_r;
   logic [1:0]  head_r;
   logic [1:0]  tail_r;
   logic        wbReady_r;
   logic        empty_r;

   logic        accept_s;
   logic        enqueue_s;
   logic        commit_s;
   logic [2:0]  countNext_s;
   logic [15:0] rdData1_s;
   logic [15:0] rdData2_s;
   logic [7:0]  pending_s;

   function automatic logic [1:0] nextPtr(input logic [1:0] p);
      return (p == 2'(WB_DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   function automatic logic [1:0] slotOf(input logic [1:0] h, input int k);
      logic [2:0] s;
      s = {1'b0, h} + 3'(k);
      if (s >= 3'(WB_DEPTH)) begin
         s = s - 3'(WB_DEPTH);
      end else begin
         s = s;
      end
      return s[1:0];
   endfunction

   // Handshake, commit and occupancy arithmetic.
   always_comb begin
      accept_s = i_wbValid & wbReady_r;
`ifdef RF_ZERO_REG_EN
      enqueue_s = accept_s & (i_wbAddr != 3'd0);
`else
      enqueue_s = accept_s;
`endif
      commit_s    = (count_r != 3'd0) & ~i_wrHold;
      countNext_s = count_r + {2'b00, enqueue_s} - {2'b00, commit_s};
   end

   // Queue pointers, entries and registered status flags.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         count_r   <= 3'd0;
         head_r    <= 2'd0;
         tail_r    <= 2'd0;
         wbReady_r <= 1'b1;
         empty_r   <= 1'b1;
         for (int i = 0; i < 4; i++) begin
            qAddr_r[i] <= 3'd0;
            qData_r[i] <= 16'h0000;
         end
      end else begin
         if (enqueue_s) begin
            qAddr_r[tail_r] <= i_wbAddr;
            qData_r[tail_r] <= i_wbData;
            tail_r          <= nextPtr(tail_r);
         end else begin
            tail_r <= tail_r;
         end
         if (commit_s) begin
            head_r <= nextPtr(head_r);
         end else begin
            head_r <= head_r;
         end
         count_r   <= countNext_s;
         wbReady_r <= (countNext_s < 3'(WB_DEPTH));
         empty_r   <= (countNext_s == 3'd0);
      end
   end

   // Register array: head entry drains into it, at most one per cycle.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int i = 0; i < 8; i++) begin
            regs_r[i] <= RST_VAL;
         end
      end else if (commit_s) begin
         regs_r[qAddr_r[head_r]] <= qData_r[head_r];
      end else begin
         regs_r[0] <= regs_r[0];
      end
   end

   // Forwarding reads: walk oldest to youngest so the youngest match wins.
   always_comb begin
      logic [1:0] idx;
      logic       inQ;
      rdData1_s = regs_r[i_rdAddr1];
      rdData2_s = regs_r[i_rdAddr2];
      pending_s = 8'h00;
      for (int k = 0; k < WB_DEPTH; k++) begin
         idx       = slotOf(head_r, k);
         inQ       = (3'(k) < count_r);
         rdData1_s = (inQ && (qAddr_r[idx] == i_rdAddr1)) ? qData_r[idx] : rdData1_s;
         rdData2_s = (inQ && (qAddr_r[idx] == i_rdAddr2)) ? qData_r[idx] : rdData2_s;
         pending_s = pending_s | (inQ ? (8'd1 << qAddr_r[idx]) : 8'h00);
      end
`ifdef RF_ZERO_REG_EN
      rdData1_s = (i_rdAddr1 == 3'd0) ? 16'h0000 : rdData1_s;
      rdData2_s = (i_rdAddr2 == 3'd0) ? 16'h0000 : rdData2_s;
`endif
   end

   assign o_wbReady = wbReady_r;
   assign o_empty   = empty_r;
   assign o_pending = pending_s;
   assign o_rdData1 = rdData1_s;
   assign o_rdData2 = rdData2_s;

endmodule

// File: tb/tb_rf_writeback_file.sv
// Scoreboard bench for rf_writeback_file: stimulus queues expectations, a negedge monitor checks them.
module tb_rf_writeback_file;

   logic        clk;
   logic        rstn;
   logic        wbValid;
   logic [2:0]  wbAddr;
   logic [15:0] wbData;
   logic        wbReady;
   logic        wrHold;
   logic [2:0]  rdAddr1;
   logic [2:0]  rdAddr2;
   logic [15:0] rdData1;
   logic [15:0] rdData2;
   logic [7:0]  pending;
   logic        empty;

   typedef struct {
      int          kind;
      logic [15:0] exp;
      int          step;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   step   = 0;

   rf_writeback_file #(.WB_DEPTH(2), .RST_VAL(16'h0000)) dut (
      .i_clk(clk), .i_rstn(rstn), .i_wbValid(wbValid), .i_wbAddr(wbAddr),
      .i_wbData(wbData), .o_wbReady(wbReady), .i_wrHold(wrHold),
      .i_rdAddr1(rdAddr1), .i_rdAddr2(rdAddr2), .o_rdData1(rdData1),
      .o_rdData2(rdData2), .o_pending(pending), .o_empty(empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // kinds: 0 rdData1, 1 rdData2, 2 pending, 3 empty, 4 wbReady
   task automatic expectV(input int kind, input logic [15:0] v);
      exp_t e;
      e.kind = kind;
      e.exp  = v;
      e.step = step;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      step++;
   endtask

   // Monitor: drain everything queued for this cycle.
   always @(negedge clk) begin
      exp_t        e;
      logic [15:0] act;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.kind)
            0: act = rdData1;
            1: act = rdData2;
            2: act = {8'h00, pending};
            3: act = {15'h0000, empty};
            default: act = {15'h0000, wbReady};
         endcase
         checks++;
         if (act !== e.exp) begin
            errors++;
            $display("FAIL step%0d kind%0d: got %h expected %h", e.step, e.kind, act, e.exp);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rstn = 1'b0; wbValid = 1'b0; wbAddr = 3'd0; wbData = 16'h0000;
      wrHold = 1'b0; rdAddr1 = 3'd0; rdAddr2 = 3'd0;
      tick();
      // reset state on every address of both ports
      for (int a = 0; a < 8; a++) begin
         rdAddr1 = 3'(a);
         rdAddr2 = 3'(7 - a);
         expectV(0, 16'h0000);
         expectV(1, 16'h0000);
         tick();
      end
      expectV(3, 16'h0001); expectV(4, 16'h0001); expectV(2, 16'h0000);
      tick();
      rstn = 1'b1;
      tick();

      // single write r3, visible next cycle, committed the one after
      wbValid = 1'b1; wbAddr = 3'd3; wbData = 16'hBEEF;
      tick();
      wbValid = 1'b0; rdAddr1 = 3'd3; rdAddr2 = 3'd3;
      expectV(0, 16'hBEEF); expectV(2, 16'h0008); expectV(3, 16'h0000);
      tick();
      expectV(0, 16'hBEEF); expectV(1, 16'hBEEF); expectV(2, 16'h0000); expectV(3, 16'h0001);
      tick();

      // held queue fills, youngest forwarded, third refused
      wrHold = 1'b1;
      wbValid = 1'b1; wbAddr = 3'd5; wbData = 16'h1111;
      tick();
      wbData = 16'h2222;
      tick();
      rdAddr1 = 3'd5; wbData = 16'h3333;
      expectV(4, 16'h0000); expectV(0, 16'h2222); expectV(2, 16'h0020); expectV(3, 16'h0000);
      tick();
      expectV(4, 16'h0000); expectV(0, 16'h2222); expectV(2, 16'h0020);
      wbValid = 1'b0; wrHold = 1'b0;
      tick();
      expectV(0, 16'h2222); expectV(2, 16'h0020); expectV(4, 16'h0001);
      tick();
      expectV(0, 16'h2222); expectV(2, 16'h0000); expectV(3, 16'h0001);
      tick();

      // full queue, hold drops with valid high: accept only on the following edge
      wrHold = 1'b1;
      wbValid = 1'b1; wbAddr = 3'd1; wbData = 16'h0101;
      tick();
      wbAddr = 3'd2; wbData = 16'h0202;
      tick();
      expectV(4, 16'h0000); expectV(2, 16'h0006);
      wrHold = 1'b0; wbAddr = 3'd6; wbData = 16'h00AA;
      rdAddr1 = 3'd6; rdAddr2 = 3'd1;
      tick();
      expectV(4, 16'h0001); expectV(2, 16'h0004); expectV(0, 16'h0000); expectV(1, 16'h0101);
      tick();
      wbValid = 1'b0; rdAddr2 = 3'd2;
      expectV(2, 16'h0040); expectV(0, 16'h00AA); expectV(1, 16'h0202);
      expectV(4, 16'h0001); expectV(3, 16'h0000);
      tick();
      expectV(3, 16'h0001); expectV(0, 16'h00AA); expectV(2, 16'h0000);
      tick();

      // asynchronous reset with two entries queued
      wrHold = 1'b1;
      wbValid = 1'b1; wbAddr = 3'd4; wbData = 16'h4444;
      tick();
      wbAddr = 3'd7; wbData = 16'h7777;
      tick();
      wbValid = 1'b0; rdAddr1 = 3'd4; rdAddr2 = 3'd7;
      expectV(2, 16'h0090); expectV(3, 16'h0000); expectV(0, 16'h4444); expectV(1, 16'h7777);
      tick();
      #2 rstn = 1'b0;
      #1;
      expectV(3, 16'h0001); expectV(2, 16'h0000); expectV(0, 16'h0000);
      expectV(1, 16'h0000); expectV(4, 16'h0001);
      tick();
      rstn = 1'b1; wrHold = 1'b0;
      tick();

      // register 0 write
      expectV(4, 16'h0001);
      wbValid = 1'b1; wbAddr = 3'd0; wbData = 16'hFFFF;
      tick();
      wbValid = 1'b0; rdAddr1 = 3'd0; rdAddr2 = 3'd0;
`ifdef RF_ZERO_REG_EN
      expectV(3, 16'h0001); expectV(2, 16'h0000); expectV(0, 16'h0000); expectV(4, 16'h0001);
`else
      expectV(3, 16'h0000); expectV(2, 16'h0001); expectV(0, 16'hFFFF); expectV(4, 16'h0001);
`endif
      tick();
`ifdef RF_ZERO_REG_EN
      expectV(0, 16'h0000); expectV(1, 16'h0000); expectV(3, 16'h0001);
`else
      expectV(0, 16'hFFFF); expectV(1, 16'hFFFF); expectV(3, 16'h0001);
`endif
      tick();
      tick();
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
